// File: rtl/sw_host_bridge.sv
// sw_host_bridge: loads alignment jobs from a UART over Avalon-MM, runs the core, returns its result
module sw_host_bridge #(
    parameter int REF_MAX_LEN  = 128,
    parameter int READ_MAX_LEN = 128,
    parameter int SCORE_W      = 10,
    localparam int LEN_W = $clog2((REF_MAX_LEN > READ_MAX_LEN ? REF_MAX_LEN : READ_MAX_LEN) + 1)
) (
    input  logic                        avm_clk,
    input  logic                        avm_rst_n,
    output logic [4:0]                  avm_address,
    output logic                        avm_read,
    input  logic [31:0]                 avm_readdata,
    output logic                        avm_write,
    output logic [31:0]                 avm_writedata,
    input  logic                        avm_waitrequest,
    input  logic                        core_o_ready,
    output logic                        core_i_valid,
    output logic [2*REF_MAX_LEN-1:0]    core_i_sequence_ref,
    output logic [2*READ_MAX_LEN-1:0]   core_i_sequence_read,
    output logic [LEN_W-1:0]            core_i_seq_ref_length,
    output logic [LEN_W-1:0]            core_i_seq_read_length,
    output logic                        core_i_ready,
    input  logic                        core_o_valid,
    input  logic signed [SCORE_W-1:0]   core_o_alignment_score,
    input  logic [LEN_W-1:0]            core_o_column,
    input  logic [LEN_W-1:0]            core_o_row
);
    typedef enum logic [2:0] {RXQ, RXRD, CHECK, CREQ, CWAIT, TXQ, TXWR} state_t;

    localparam int REF_PW = 8 * ((REF_MAX_LEN + 3) / 4);
    localparam int READ_PW = 8 * ((READ_MAX_LEN + 3) / 4);
    localparam logic [7:0] REF_MAX = 8'(REF_MAX_LEN);
    localparam logic [7:0] READ_MAX = 8'(READ_MAX_LEN);

    state_t state, state_nx;
    logic [REF_PW-1:0] ref_seq;
    logic [READ_PW-1:0] read_seq;
    logic [7:0] ref_len, read_len, cnt;
    logic [31:0] tx_buf;
    logic [2:0] tx_left;
    logic acc, in_ref, seq_last, len_bad;
    logic [7:0] rx_byte, ref_bytes, read_bytes, seq_k, rd_k, rem, mask;
    logic [10:0] off;
    logic unused_rd;

    assign unused_rd = ^avm_readdata[31:8];
    assign acc = !avm_waitrequest;
    assign rx_byte = avm_readdata[7:0];
    assign core_i_sequence_ref = ref_seq[2*REF_MAX_LEN-1:0];
    assign core_i_sequence_read = read_seq[2*READ_MAX_LEN-1:0];
    assign core_i_seq_ref_length = ref_len[LEN_W-1:0];
    assign core_i_seq_read_length = read_len[LEN_W-1:0];

    // seq_k indexes sequence bytes after the two length bytes; mask clears bases past the length
    always_comb begin
        ref_bytes = 8'(({1'b0, ref_len} + 9'd3) >> 2);
        read_bytes = 8'(({1'b0, read_len} + 9'd3) >> 2);
        seq_k = cnt - 8'd2;
        in_ref = seq_k < ref_bytes;
        rd_k = seq_k - ref_bytes;
        rem = in_ref ? ref_len - {seq_k[5:0], 2'b00} : read_len - {rd_k[5:0], 2'b00};
        mask = rem > 8'd3 ? 8'hFF : ~(8'hFF << {rem[1:0], 1'b0});
        off = {in_ref ? seq_k : rd_k, 3'b000};
        seq_last = seq_k == ref_bytes + read_bytes - 8'd1;
        len_bad = ref_len == 8'd0 || ref_len > REF_MAX || rx_byte == 8'd0 || rx_byte > READ_MAX;
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) state <= RXQ;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        avm_read = 1'b0;
        avm_write = 1'b0;
        avm_address = 5'h08;
        core_i_valid = 1'b0;
        core_i_ready = 1'b0;
        unique case (state)
            RXQ: begin
                avm_read = 1'b1;
                if (acc && avm_readdata[7]) state_nx = RXRD;
            end
            RXRD: begin
                avm_read = 1'b1;
                avm_address = 5'h00;
                if (acc) state_nx = cnt == 8'd1 && len_bad ? TXQ : cnt > 8'd1 && seq_last ? CHECK : RXQ;
            end
            CHECK: state_nx = CREQ;
            CREQ: begin
                core_i_valid = 1'b1;
                if (core_o_ready) state_nx = CWAIT;
            end
            CWAIT: begin
                core_i_ready = 1'b1;
                if (core_o_valid) state_nx = TXQ;
            end
            TXQ: begin
                avm_read = 1'b1;
                if (acc && avm_readdata[6]) state_nx = TXWR;
            end
            TXWR: begin
                avm_write = 1'b1;
                avm_address = 5'h04;
                if (acc) state_nx = tx_left == 3'd1 ? RXQ : TXQ;
            end
            default: state_nx = RXQ;
        endcase
        avm_writedata = avm_write ? {24'd0, tx_buf[31:24]} : 32'd0;
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            ref_seq <= '0;
            read_seq <= '0;
            ref_len <= '0;
            read_len <= '0;
            cnt <= '0;
            tx_buf <= '0;
            tx_left <= '0;
        end else begin
            if (state == RXRD && acc) begin
                if (cnt == 8'd0) begin
                    ref_len <= rx_byte;
                    read_len <= 8'd0;
                    ref_seq <= '0;
                    read_seq <= '0;
                end else if (cnt == 8'd1) begin
                    read_len <= rx_byte;
                    if (len_bad) begin
                        tx_buf <= 32'hFF00_0000;
                        tx_left <= 3'd1;
                    end
                end else if (in_ref) begin
                    ref_seq[off +: 8] <= rx_byte & mask;
                end else begin
                    read_seq[off +: 8] <= rx_byte & mask;
                end
                cnt <= (cnt == 8'd1 && len_bad) || (cnt > 8'd1 && seq_last) ? 8'd0 : cnt + 8'd1;
            end
            if (state == CWAIT && core_o_valid) begin
                tx_buf <= {16'(core_o_alignment_score), 8'(core_o_column), 8'(core_o_row)};
                tx_left <= 3'd4;
            end
            if (state == TXWR && acc) begin
                tx_buf <= tx_buf << 8;
                tx_left <= tx_left - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_sw_host_bridge.sv
// tb_sw_host_bridge: UART/core behavioural models with directed jobs and hand-computed responses
module tb_sw_host_bridge;
    logic avm_clk = 1'b0;
    logic avm_rst_n = 1'b0;
    logic [4:0] avm_address;
    logic avm_read, avm_write, avm_waitrequest;
    logic [31:0] avm_readdata, avm_writedata;
    logic core_o_ready, core_i_valid, core_i_ready, core_o_valid;
    logic [255:0] core_i_sequence_ref, core_i_sequence_read;
    logic [7:0] core_i_seq_ref_length, core_i_seq_read_length, core_o_column, core_o_row;
    logic signed [9:0] core_o_alignment_score;

    always #5 avm_clk = ~avm_clk;

    sw_host_bridge dut (
        .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .core_o_ready(core_o_ready), .core_i_valid(core_i_valid),
        .core_i_sequence_ref(core_i_sequence_ref), .core_i_sequence_read(core_i_sequence_read),
        .core_i_seq_ref_length(core_i_seq_ref_length), .core_i_seq_read_length(core_i_seq_read_length),
        .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
        .core_o_alignment_score(core_o_alignment_score), .core_o_column(core_o_column), .core_o_row(core_o_row)
    );

    int checks = 0, errors = 0;
    logic [7:0] rx_q[$], tx_q[$];
    int stall = 0, tx_busy_cfg = 0, tx_busy = 0, wait_cnt = 0, rdy_dly = 0, rdy_cnt = 0, ov_cnt = 0;
    int starts = 0, s0 = 0;
    bit in_prog = 0, tx_ok = 0, pend = 0, vld_prev = 0, core_hold = 0;
    logic [4:0] l_addr;
    logic l_rd, l_wr;
    logic [31:0] l_wd;
    logic [255:0] cap_ref, cap_read, snap_ref, snap_read, er, ed;
    logic [15:0] cap_len, snap_len;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic complete();
        logic rx_rdy, txr;
        if (avm_read) begin
            check("rd_addr", avm_address == 5'h00 || avm_address == 5'h08, 1'b1);
            if (avm_address == 5'h08) begin
                rx_rdy = rx_q.size() != 0;
                txr = tx_busy == 0;
                if (tx_busy > 0 && !rx_rdy) tx_busy--;
                tx_ok = txr;
                avm_readdata = {24'hA5A5A5, rx_rdy, txr, 6'h15};
            end else begin
                check("rx_avail", rx_q.size() != 0, 1'b1);
                avm_readdata = {24'h5A5A5A, rx_q.size() != 0 ? rx_q.pop_front() : 8'h00};
            end
        end else begin
            check("wr_addr", avm_address, 5'h04);
            check("wr_hi", avm_writedata[31:8], 24'd0);
            check("tx_gate", tx_ok, 1'b1);
            tx_q.push_back(avm_writedata[7:0]);
            tx_ok = 0;
            tx_busy = tx_busy_cfg;
        end
    endtask

    always @(negedge avm_clk) begin
        if (!avm_rst_n) begin
            in_prog = 0;
            avm_waitrequest = 0;
        end else if (avm_read || avm_write) begin
            check("rw_excl", avm_read & avm_write, 1'b0);
            if (in_prog)
                check("bus_stable", {avm_address, avm_read, avm_write, avm_writedata}, {l_addr, l_rd, l_wr, l_wd});
            else begin
                in_prog = 1;
                wait_cnt = stall;
                {l_addr, l_rd, l_wr, l_wd} = {avm_address, avm_read, avm_write, avm_writedata};
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                avm_waitrequest = 1;
                avm_readdata = '1;
            end else begin
                avm_waitrequest = 0;
                in_prog = 0;
                complete();
            end
        end else begin
            if (in_prog) check("bus_drop", {avm_read, avm_write}, {l_rd, l_wr});
            in_prog = 0;
            avm_waitrequest = 0;
            avm_readdata = '1;
        end
    end

    always @(negedge avm_clk) begin
        if (!avm_rst_n) begin
            core_o_ready = 0;
            core_o_valid = 0;
            pend = 0;
            vld_prev = 0;
            rdy_cnt = 0;
            ov_cnt = 0;
        end else begin
            if (core_i_valid) begin
                if (pend) begin
                    check("ref_stable", core_i_sequence_ref, snap_ref);
                    check("read_stable", core_i_sequence_read, snap_read);
                    check("len_stable", {core_i_seq_ref_length, core_i_seq_read_length}, snap_len);
                end
                pend = 1;
                snap_ref = core_i_sequence_ref;
                snap_read = core_i_sequence_read;
                snap_len = {core_i_seq_ref_length, core_i_seq_read_length};
                if (rdy_cnt < rdy_dly) begin
                    rdy_cnt++;
                    core_o_ready = 0;
                end else begin
                    core_o_ready = 1;
                    rdy_cnt = 0;
                    pend = 0;
                    starts++;
                    {cap_ref, cap_read, cap_len} = {snap_ref, snap_read, snap_len};
                end
            end else begin
                core_o_ready = 0;
                pend = 0;
            end
            if (vld_prev) check("rdy_drop", core_i_ready, 1'b0);
            vld_prev = 0;
            if (core_i_ready && !core_hold) begin
                if (ov_cnt < 2) begin
                    ov_cnt++;
                    core_o_valid = 0;
                end else begin
                    core_o_valid = 1;
                    ov_cnt = 0;
                    vld_prev = 1;
                end
            end else begin
                core_o_valid = 0;
                ov_cnt = 0;
            end
        end
    end

    task automatic push(input int n, input logic [63:0] v);
        s0 = starts;
        tx_busy = tx_busy_cfg;
        for (int i = 0; i < n; i++) rx_q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic result(input logic signed [9:0] sc, input logic [7:0] col, input logic [7:0] row);
        core_o_alignment_score = sc;
        core_o_column = col;
        core_o_row = row;
    endtask

    task automatic run_job(input string tag, input int ntx, input logic [31:0] exp_tx, input int exp_st);
        for (int i = 0; i < 5000 && tx_q.size() < ntx; i++) @(negedge avm_clk);
        repeat (30) @(negedge avm_clk);
        check({tag, "_ntx"}, tx_q.size(), ntx);
        for (int i = 0; i < ntx; i++)
            check({tag, "_tx"}, i < tx_q.size() ? {1'b0, tx_q[i]} : 9'h100, exp_tx[8*(ntx-1-i) +: 8]);
        check({tag, "_starts"}, starts - s0, exp_st);
        check({tag, "_rx_left"}, rx_q.size(), 0);
        tx_q.delete();
    endtask

    task automatic job44();
        result(10'sd4, 8'd4, 8'd4);
        push(4, 64'h0404E4E4);
        run_job("j44", 4, 32'h00040404, 1);
        check("j44_ref", cap_ref, 256'hE4);
        check("j44_read", cap_read, 256'hE4);
        check("j44_len", cap_len, 16'h0404);
    endtask

    task automatic job53();
        result(-10'sd1, 8'd5, 8'd3);
        push(5, 64'h0503FFFFFF);
        run_job("j53", 4, 32'hFFFF0503, 1);
        check("j53_ref", cap_ref, 256'h3FF);
        check("j53_read", cap_read, 256'h3F);
        check("j53_len", cap_len, 16'h0503);
    endtask

    initial begin
        avm_waitrequest = 0;
        avm_readdata = '1;
        core_o_ready = 0;
        core_o_valid = 0;
        result(10'sd0, 8'd0, 8'd0);
        repeat (3) @(negedge avm_clk);
        check("rst_read", avm_read, 1'b1);
        check("rst_addr", avm_address, 5'h08);
        check("rst_write", {avm_write, avm_writedata}, 33'd0);
        check("rst_core", {core_i_valid, core_i_ready}, 2'b00);
        check("rst_seq", {core_i_sequence_ref, core_i_sequence_read}, 512'd0);
        check("rst_len", {core_i_seq_ref_length, core_i_seq_read_length}, 16'd0);
        @(posedge avm_clk);
        #2 avm_rst_n = 1;
        @(negedge avm_clk);
        check("first_poll", {avm_read, avm_address}, {1'b1, 5'h08});

        job44();
        job53();

        result(-10'sd3, 8'h80, 8'h7F);
        push(2, 64'h8080);
        for (int k = 0; k < 32; k++) begin
            er[8*k +: 8] = 8'(k * 7 + 1);
            rx_q.push_back(8'(k * 7 + 1));
        end
        for (int k = 0; k < 32; k++) begin
            ed[8*k +: 8] = 8'(k) ^ 8'h5A;
            rx_q.push_back(8'(k) ^ 8'h5A);
        end
        run_job("j128", 4, 32'hFFFD807F, 1);
        check("j128_ref", cap_ref, er);
        check("j128_read", cap_read, ed);
        check("j128_len", cap_len, 16'h8080);

        push(2, 64'h0004);
        run_job("err_zero", 1, 32'hFF, 0);
        push(2, 64'hC804);
        run_job("err_200", 1, 32'hFF, 0);
        push(2, 64'h0481);
        run_job("err_read129", 1, 32'hFF, 0);

        result(10'sd511, 8'd4, 8'd2);
        push(4, 64'h04021B39);
        run_job("j42", 4, 32'h01FF0402, 1);
        check("j42_ref", cap_ref, 256'h1B);
        check("j42_read", cap_read, 256'h9);

        stall = 5;
        rdy_dly = 3;
        job44();
        job53();
        stall = 0;
        rdy_dly = 0;
        tx_busy_cfg = 10;
        job44();
        tx_busy_cfg = 0;

        core_hold = 1;
        result(10'sd4, 8'd4, 8'd4);
        push(4, 64'h0404E4E4);
        for (int i = 0; i < 5000 && !core_i_ready; i++) @(negedge avm_clk);
        check("cwait_reach", core_i_ready, 1'b1);
        #2 avm_rst_n = 0;
        #1;
        check("rst_cwait_rdy", core_i_ready, 1'b0);
        check("rst_cwait_bus", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, 5'h08});
        check("rst_cwait_seq", core_i_sequence_ref, 256'd0);
        rx_q.delete();
        tx_q.delete();
        core_hold = 0;
        repeat (2) @(negedge avm_clk);
        @(posedge avm_clk);
        #2 avm_rst_n = 1;
        @(negedge avm_clk);
        check("post_rst_poll", {avm_read, avm_address}, {1'b1, 5'h08});
        job44();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sw_host_bridge.md
SW_HOST_BRIDGE -- requirements
Module: sw_host_bridge

Interface
REQ-001 SHALL have parameter REF_MAX_LEN, default 128, max reference bases (1..255).
REQ-002 SHALL have parameter READ_MAX_LEN, default 128, max read bases (1..255).
REQ-003 SHALL have parameter SCORE_W, default 10, signed alignment-score width (2..16).
REQ-004 SHALL define LEN_W = clog2(max(REF_MAX_LEN, READ_MAX_LEN)+1); this is a derived width, not a parameter.
REQ-005 Ports: avm_clk, in, 1, sole clock; all logic samples on its rising edge.
REQ-006 Ports: avm_rst_n, in, 1, asynchronous active-low reset.
REQ-007 Ports: avm_address out 5, avm_read out 1, avm_readdata in 32, avm_write out 1, avm_writedata out 32, avm_waitrequest in 1; this is the Avalon-MM master to the UART.
REQ-008 Ports: core_o_ready in 1, core_i_valid out 1, core_i_sequence_ref out 2*REF_MAX_LEN, core_i_sequence_read out 2*READ_MAX_LEN, core_i_seq_ref_length out LEN_W, core_i_seq_read_length out LEN_W.
REQ-009 Ports: core_i_ready out 1, core_o_valid in 1, core_o_alignment_score in SCORE_W (signed), core_o_column in LEN_W, core_o_row in LEN_W.

Function
REQ-010 UART map SHALL be: RX data 0x00, TX data 0x04, status 0x08; status bit7 = RX ready, bit6 = TX ready.
REQ-011 Bus rule: a started read/write SHALL hold address, read, write and writedata stable until a cycle with avm_waitrequest=0; read and write SHALL never be high together.
REQ-012 States SHALL be: RXQ (poll status), RXRD (read byte), CHECK, CREQ, CWAIT, TXQ (poll status), TXWR (write byte).
REQ-013 RXQ: on accepted status read with bit7=1, go RXRD and read 0x00; otherwise re-read 0x08.
REQ-014 Job frame SHALL be: byte0 = ref_len, byte1 = read_len, then ceil(ref_len/4) ref bytes, then ceil(read_len/4) read bytes.
REQ-015 Packing: bits[2j+1:2j] of the k-th sequence byte SHALL be base 4k+j, stored at sequence-bus bits [2(4k+j)+1 : 2(4k+j)]; bits beyond the length SHALL be zero.
REQ-016 After byte1: if either length is 0 or exceeds its MAX, SHALL go TXQ with a 1-byte error response 0xFF, no sequence bytes are consumed, and the core SHALL not be started.
REQ-017 Valid lengths: when the sequence bytes are complete, go CHECK (1 cycle), then CREQ; with read_len ≤ 4 and ref_len ≤ 4, the last sequence byte arrives at frame byte 3.
REQ-018 Sequence registers SHALL be cleared to zero at the start of each frame (byte0 accepted).
REQ-019 CREQ: core_i_valid=1 with stable sequences and lengths until core_o_ready=1 in the same cycle; then core_i_valid=0 and go CWAIT.
REQ-020 CWAIT: core_i_ready=1; on core_o_valid=1 capture score, column and row, drop core_i_ready the next cycle and go TXQ.
REQ-021 Success response SHALL be 4 bytes, in order: score sign-extended to 16 bits MSB byte, score LSB byte, column zero-extended to 8 bits, row zero-extended to 8 bits.
REQ-022 TXQ/TXWR: poll 0x08 until bit6=1, then write the byte to 0x04 with avm_writedata[7:0]=byte and [31:8]=0; repeat per byte.
REQ-023 After the last response byte is accepted, go RXQ and poll status; consecutive jobs SHALL be unlimited.
REQ-024 RX data SHALL use avm_readdata[7:0] only; bits [31:8] are ignored.
REQ-025 Byte and base counters SHALL be sized for 255-base frames without wrap.
REQ-026 core_o_valid outside CWAIT and core_o_ready outside CREQ SHALL be ignored.

Reset
REQ-027 While avm_rst_n=0, outputs SHALL be: avm_read=1, avm_address=0x08, avm_write=0, avm_writedata=0, core_i_valid=0, core_i_ready=0, sequences/lengths=0; state RXQ.
REQ-028 Reset asserted mid-frame, mid-core or mid-transmit SHALL abandon the job immediately; after release the first action SHALL be a status read.

Verification
REQ-029 Lengths 4/4, ref byte 0xE4, read byte 0xE4; core returns score 4, column 4, row 4 -> core sees sequences 0xE4 and lengths 4/4; TX bytes 0x00,0x04,0x04,0x04.
REQ-030 Lengths 128/128, 32+32 bytes; core returns score -3 -> TX bytes 0xFF,0xFD, then column, row.
REQ-031 ref_len=0 or 200 (MAX 128) -> single TX byte 0xFF, core_i_valid never asserted, next frame is accepted normally.
REQ-032 avm_waitrequest held high 5 cycles on every access, and core_o_ready delayed 3 cycles -> signals stay stable and the result is identical to a zero-stall run.
REQ-033 Status bit6=0 for 10 polls before each TX byte -> no write issued until bit6=1; no byte is lost or duplicated.
REQ-034 Reset pulse during CWAIT -> core_i_ready=0 immediately; a following fresh frame completes correctly.
